// File: rtl/clk_rate_pkg.sv
// Shared types and defaults for the clock-rate measurement responder.
package clk_rate_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COUNT    = 2'd1,
      WAIT_ACK = 2'd2
   } clk_rate_state_t;

   localparam int CLK_RATE_WIDTH       = 24;
   localparam int CLK_RATE_SYNC_STAGES = 2;

endpackage

// File: rtl/clk_rate_bit_sync.sv
// Single-bit flop chain bringing a reference-domain control bit into clk_test.
module clk_rate_bit_sync #(
   parameter int STAGES = 2
) (
   input  logic clk_test,
   input  logic async_reset_clk_test,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the incoming level through the chain; the last stage is the safe copy.
   always_ff @(posedge clk_test or posedge async_reset_clk_test) begin
      if (async_reset_clk_test) begin
         sync_q <= {STAGES{1'b0}};
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rate_responder.sv
// Test-clock-side responder: counts clk_test cycles inside the synchronized gate
// window and publishes the result with a request/acknowledge toggle handshake.
module clk_rate_responder
   import clk_rate_pkg::*;
#(
   parameter int WIDTH       = CLK_RATE_WIDTH,
   parameter int SYNC_STAGES = CLK_RATE_SYNC_STAGES
) (
   input  logic             clk_test,
   input  logic             async_reset_clk_test,
   input  logic             gate_in,
   input  logic             ack_tgl_in,
   output logic [WIDTH-1:0] count_out,
   output logic             overflow_out,
   output logic             req_tgl_out,
   output logic             busy,
   output logic             dropped
);

   localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

   logic             gate_s;
   logic             ack_s;
   logic             rise_s;
   logic             fall_s;

   clk_rate_state_t  state_q;
   logic             gate_prev_q;
   logic [WIDTH-1:0] cnt_q;
   logic             ovf_q;
   logic [WIDTH-1:0] count_q;
   logic             overflow_q;
   logic             req_tgl_q;
   logic             busy_q;
   logic             dropped_q;

   clk_rate_bit_sync #(.STAGES(SYNC_STAGES)) u_gate_sync (
      .clk_test             (clk_test),
      .async_reset_clk_test (async_reset_clk_test),
      .d_i                  (gate_in),
      .q_o                  (gate_s)
   );

   clk_rate_bit_sync #(.STAGES(SYNC_STAGES)) u_ack_sync (
      .clk_test             (clk_test),
      .async_reset_clk_test (async_reset_clk_test),
      .d_i                  (ack_tgl_in),
      .q_o                  (ack_s)
   );

   // Edges derive from one registered level, so rise and fall are mutually exclusive.
   assign rise_s = gate_s & ~gate_prev_q;
   assign fall_s = ~gate_s & gate_prev_q;

   // FSM, saturating counter and all published outputs.
   always_ff @(posedge clk_test or posedge async_reset_clk_test) begin
      if (async_reset_clk_test) begin
         state_q     <= IDLE;
         gate_prev_q <= 1'b0;
         cnt_q       <= {WIDTH{1'b0}};
         ovf_q       <= 1'b0;
         count_q     <= {WIDTH{1'b0}};
         overflow_q  <= 1'b0;
         req_tgl_q   <= 1'b0;
         busy_q      <= 1'b0;
         dropped_q   <= 1'b0;
      end else begin
         gate_prev_q <= gate_s;
         case (state_q)
            IDLE: begin
               if (rise_s) begin
                  cnt_q   <= {{(WIDTH-1){1'b0}}, 1'b1};
                  ovf_q   <= 1'b0;
                  state_q <= COUNT;
                  busy_q  <= 1'b1;
               end
            end
            COUNT: begin
               if (fall_s) begin
                  count_q    <= cnt_q;
                  overflow_q <= ovf_q;
                  req_tgl_q  <= ~req_tgl_q;
                  dropped_q  <= 1'b0;
                  state_q    <= WAIT_ACK;
               end else if (gate_s) begin
                  // Hold at all-ones rather than wrap; the flag records the lost count.
                  if (cnt_q == CNT_MAX) begin
                     ovf_q <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
                  end
               end
            end
            WAIT_ACK: begin
               if (rise_s) begin
                  dropped_q <= 1'b1;
               end
               if (ack_s == req_tgl_q) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign count_out    = count_q;
   assign overflow_out = overflow_q;
   assign req_tgl_out  = req_tgl_q;
   assign busy         = busy_q;
   assign dropped      = dropped_q;

endmodule

// File: tb/tb_clk_rate_responder.sv
// Directed bench for clk_rate_responder: a default-width and a 4-bit instance
// share the gate and are checked against hand-computed vectors.
module tb_clk_rate_responder;

   logic        clk_test = 1'b0;
   logic        rst      = 1'b1;
   logic        gate     = 1'b0;
   logic        ack24    = 1'b0;
   logic        ack4     = 1'b0;

   logic [23:0] count24;
   logic        ovf24, req24, busy24, drop24;
   logic [3:0]  count4;
   logic        ovf4, req4, busy4, drop4;

   int n_tests = 0;
   int n_fail  = 0;
   logic exp_req = 1'b0;

   typedef struct {
      int   len;
      int   exp24;
      logic ovf24;
      int   exp4;
      logic ovf4;
   } vec_t;

   vec_t vecs[7];

   always #5 clk_test = ~clk_test;

   clk_rate_responder #(.WIDTH(24), .SYNC_STAGES(2)) dut24 (
      .clk_test             (clk_test),
      .async_reset_clk_test (rst),
      .gate_in              (gate),
      .ack_tgl_in           (ack24),
      .count_out            (count24),
      .overflow_out         (ovf24),
      .req_tgl_out          (req24),
      .busy                 (busy24),
      .dropped              (drop24)
   );

   clk_rate_responder #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
      .clk_test             (clk_test),
      .async_reset_clk_test (rst),
      .gate_in              (gate),
      .ack_tgl_in           (ack4),
      .count_out            (count4),
      .overflow_out         (ovf4),
      .req_tgl_out          (req4),
      .busy                 (busy4),
      .dropped              (drop4)
   );

   task automatic cyc(input int n);
      repeat (n) @(posedge clk_test);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // One gate window of len cycles, publish-latency check, optional ack with busy-fall check.
   task automatic pulse(input int len, input int e24, input logic o24,
                        input int e4, input logic o4, input bit do_ack);
      gate = 1'b1;
      cyc(len);
      gate = 1'b0;
      cyc(2);
      check("req_not_yet", {31'd0, req24}, {31'd0, exp_req});
      cyc(1);
      exp_req = ~exp_req;
      check("req24_toggled", {31'd0, req24}, {31'd0, exp_req});
      check("req4_toggled", {31'd0, req4}, {31'd0, exp_req});
      check("count24", {8'd0, count24}, e24);
      check("ovf24", {31'd0, ovf24}, {31'd0, o24});
      check("count4", {28'd0, count4}, e4);
      check("ovf4", {31'd0, ovf4}, {31'd0, o4});
      check("busy_pending", {31'd0, busy24}, 32'd1);
      if (do_ack) begin
         cyc(5);
         ack24 = req24;
         ack4  = req4;
         cyc(2);
         check("busy_before_ack_sync", {31'd0, busy24}, 32'd1);
         cyc(1);
         check("busy_after_ack", {31'd0, busy24}, 32'd0);
         check("busy4_after_ack", {31'd0, busy4}, 32'd0);
         cyc(3);
         check("req_single_toggle", {31'd0, req24}, {31'd0, exp_req});
      end
   endtask

   initial begin
      vecs[0] = '{len: 1,    exp24: 1,    ovf24: 1'b0, exp4: 1,  ovf4: 1'b0};
      vecs[1] = '{len: 2,    exp24: 2,    ovf24: 1'b0, exp4: 2,  ovf4: 1'b0};
      vecs[2] = '{len: 7,    exp24: 7,    ovf24: 1'b0, exp4: 7,  ovf4: 1'b0};
      vecs[3] = '{len: 15,   exp24: 15,   ovf24: 1'b0, exp4: 15, ovf4: 1'b0};
      vecs[4] = '{len: 16,   exp24: 16,   ovf24: 1'b0, exp4: 15, ovf4: 1'b1};
      vecs[5] = '{len: 20,   exp24: 20,   ovf24: 1'b0, exp4: 15, ovf4: 1'b1};
      vecs[6] = '{len: 1000, exp24: 1000, ovf24: 1'b0, exp4: 15, ovf4: 1'b1};

      // Reset state and quiet idle period.
      cyc(3);
      check("rst_count", {8'd0, count24}, 32'd0);
      check("rst_req", {31'd0, req24}, 32'd0);
      check("rst_dropped", {31'd0, drop24}, 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 10; i++) begin
         cyc(10);
         check("idle_busy", {31'd0, busy24}, 32'd0);
      end
      check("idle_ovf", {31'd0, ovf24}, 32'd0);
      check("idle_req", {31'd0, req24}, 32'd0);

      for (int i = 0; i < 7; i++) begin
         pulse(vecs[i].len, vecs[i].exp24, vecs[i].ovf24, vecs[i].exp4, vecs[i].ovf4, 1'b1);
         cyc(2);
      end

      // Ack withheld: the second window is dropped and the result is held.
      pulse(40, 40, 1'b0, 15, 1'b1, 1'b0);
      gate = 1'b1;
      cyc(50);
      gate = 1'b0;
      cyc(5);
      check("drop_flag", {31'd0, drop24}, 32'd1);
      check("drop_count_held", {8'd0, count24}, 32'd40);
      check("drop_req_held", {31'd0, req24}, {31'd0, exp_req});
      check("drop_busy", {31'd0, busy24}, 32'd1);
      ack24 = req24;
      ack4  = req4;
      cyc(4);
      check("drop_idle", {31'd0, busy24}, 32'd0);
      check("drop_not_counted", {31'd0, req24}, {31'd0, exp_req});
      pulse(30, 30, 1'b0, 15, 1'b1, 1'b1);
      check("drop_cleared", {31'd0, drop24}, 32'd0);

      // Reset in the middle of a window aborts without publishing.
      cyc(2);
      gate = 1'b1;
      cyc(300);
      check("midcount_busy", {31'd0, busy24}, 32'd1);
      rst = 1'b1;
      #1;
      check("midrst_count", {8'd0, count24}, 32'd0);
      check("midrst_req", {31'd0, req24}, 32'd0);
      check("midrst_busy", {31'd0, busy24}, 32'd0);
      check("midrst_ovf4", {31'd0, ovf4}, 32'd0);
      gate    = 1'b0;
      ack24   = 1'b0;
      ack4    = 1'b0;
      exp_req = 1'b0;
      cyc(2);
      rst = 1'b0;
      cyc(10);
      check("midrst_no_toggle", {31'd0, req24}, 32'd0);
      pulse(200, 200, 1'b0, 15, 1'b1, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
